// File: rtl/vga_draw_sched.sv
// vga_draw_sched: runs a selected set of VGA plot engines one at a time,
// lowest index first, and funnels the active engine's pixel stream onto a
// single registered framebuffer write port.
// Optional watchdog: define VGA_SCHED_WDOG_EN to bound each engine's run to
// MAX_CYC RUN cycles and flag offenders in err.
module vga_draw_sched #(
  parameter int N_ENG   = 4,
  parameter int IDX_W   = 2,
  parameter int XW      = 8,
  parameter int YW      = 8,
  parameter int CW      = 12,
  parameter int MAX_CYC = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_ENG-1:0]    eng_mask,
  output logic [N_ENG-1:0]    eng_enable,
  output logic [N_ENG-1:0]    eng_reset,
  input  logic [N_ENG-1:0]    eng_finished,
  input  logic [N_ENG*XW-1:0] eng_x,
  input  logic [N_ENG*YW-1:0] eng_y,
  input  logic [N_ENG*CW-1:0] eng_color,
  output logic                fb_we,
  output logic [XW-1:0]       fb_x,
  output logic [YW-1:0]       fb_y,
  output logic [CW-1:0]       fb_color,
  output logic [IDX_W-1:0]    cur_eng,
  output logic                busy,
  output logic                done,
  output logic [N_ENG-1:0]    err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [N_ENG-1:0]   pend_q;
  logic [N_ENG-1:0]   en_q;
  logic [N_ENG-1:0]   rst_q;
  logic               we_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [CW-1:0]      col_q;
  logic [IDX_W-1:0]   cur_q;
  logic               busy_q;
  logic               done_q;

  // Lowest-index engine still waiting in a mask (0 when mask is empty).
  function automatic logic [IDX_W-1:0] low_idx(input logic [N_ENG-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_ENG - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [N_ENG-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_ENG'(1) << idx;
  endfunction

  // Signals of the engine currently being serviced.
  logic          sel_fin;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [CW-1:0] sel_col;

  assign sel_fin = eng_finished[cur_q];
  assign sel_x   = eng_x[cur_q*XW +: XW];
  assign sel_y   = eng_y[cur_q*YW +: YW];
  assign sel_col = eng_color[cur_q*CW +: CW];

`ifdef VGA_SCHED_WDOG_EN
  localparam int CNT_W = $clog2(MAX_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic [N_ENG-1:0] err_q;
  logic             tmo;

  // Timeout fires on the MAX_CYC-th RUN cycle of the current engine.
  assign tmo = (cnt_q == CNT_W'(MAX_CYC - 1));
  assign err = err_q;
`else
  logic tmo;

  assign tmo = 1'b0;
  assign err = '0;
`endif

  // Pass sequencer: every output is registered here, strobes default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      en_q    <= '0;
      rst_q   <= '0;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      cur_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef VGA_SCHED_WDOG_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      rst_q  <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (eng_mask != '0) begin
              pend_q  <= eng_mask;
              // Restart pulse is issued during the SELECT cycle itself.
              rst_q   <= onehot(low_idx(eng_mask));
              state_q <= S_SELECT;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_SELECT: begin
          cur_q   <= low_idx(pend_q);
          en_q    <= onehot(low_idx(pend_q));
          state_q <= S_RUN;
`ifdef VGA_SCHED_WDOG_EN
          cnt_q   <= '0;
`endif
        end
        S_RUN: begin
          if (sel_fin || tmo) begin
            pend_q[cur_q] <= 1'b0;
            en_q          <= '0;
            state_q       <= S_GAP;
`ifdef VGA_SCHED_WDOG_EN
            if (!sel_fin) err_q[cur_q] <= 1'b1;
`endif
          end else begin
            we_q  <= 1'b1;
            x_q   <= sel_x;
            y_q   <= sel_y;
            col_q <= sel_col;
`ifdef VGA_SCHED_WDOG_EN
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        S_GAP: begin
          if (pend_q != '0) begin
            rst_q   <= onehot(low_idx(pend_q));
            state_q <= S_SELECT;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_enable = en_q;
  assign eng_reset  = rst_q;
  assign fb_we      = we_q;
  assign fb_x       = x_q;
  assign fb_y       = y_q;
  assign fb_color   = col_q;
  assign cur_eng    = cur_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vga_draw_sched.sv
// Bench for vga_draw_sched: stub engines plus a pass-level reference trace.
module tb_vga_draw_sched;

  localparam int N  = 4;
`ifdef VGA_SCHED_WDOG_EN
  localparam int MC = 16;
`else
  localparam int MC = 65535;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   eng_mask;
  logic [N-1:0]   eng_enable;
  logic [N-1:0]   eng_reset;
  logic [N-1:0]   eng_finished;
  logic [N*8-1:0] eng_x;
  logic [N*8-1:0] eng_y;
  logic [N*12-1:0] eng_color;
  logic           fb_we;
  logic [7:0]     fb_x;
  logic [7:0]     fb_y;
  logic [11:0]    fb_color;
  logic [1:0]     cur_eng;
  logic           busy;
  logic           done;
  logic [N-1:0]   err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_draw_sched #(
    .N_ENG(N), .IDX_W(2), .XW(8), .YW(8), .CW(12), .MAX_CYC(MC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .eng_mask(eng_mask),
    .eng_enable(eng_enable), .eng_reset(eng_reset), .eng_finished(eng_finished),
    .eng_x(eng_x), .eng_y(eng_y), .eng_color(eng_color),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
    .cur_eng(cur_eng), .busy(busy), .done(done), .err(err)
  );

  // ---------------- stub engines ----------------
  int         run_len [N];   // pixels each engine emits before finishing
  int         cnt [N];
  logic [N-1:0] fin_force;

  function automatic logic [7:0] px(int i, int j);
    return 8'(j + i * 40);
  endfunction
  function automatic logic [7:0] py(int i, int j);
    return 8'(j * 3 + i);
  endfunction
  function automatic logic [11:0] pc(int i, int j);
    return 12'(i * 256 + j * 5 + 1);
  endfunction

  always_comb begin
    eng_x = '0;
    eng_y = '0;
    eng_color = '0;
    eng_finished = '0;
    for (int i = 0; i < N; i++) begin
      eng_x[i*8 +: 8]      = px(i, cnt[i]);
      eng_y[i*8 +: 8]      = py(i, cnt[i]);
      eng_color[i*12 +: 12] = pc(i, cnt[i]);
      eng_finished[i]      = (cnt[i] == run_len[i]) | fin_force[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (eng_reset[i]) cnt[i] <= 0;
      else if (eng_enable[i] && cnt[i] != run_len[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  rs;
    logic        we;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] col;
    logic        busy;
    logic        done;
    logic [1:0]  cur;
    logic [3:0]  err;
  } obs_t;

  obs_t        expq[$];
  logic [7:0]  m_x, m_y;
  logic [11:0] m_col;
  logic [1:0]  m_cur;
  logic [3:0]  m_err;

  task automatic model_reset();
    m_x = '0; m_y = '0; m_col = '0; m_cur = '0; m_err = '0;
  endtask

  task automatic push(input logic [3:0] en, input logic [3:0] rs, input logic we,
                      input logic bsy, input logic dn);
    obs_t e;
    e.en = en; e.rs = rs; e.we = we; e.x = m_x; e.y = m_y; e.col = m_col;
    e.busy = bsy; e.done = dn; e.cur = m_cur; e.err = m_err;
    expq.push_back(e);
  endtask

  // Expected cycle-by-cycle outputs of one pass, starting the cycle after start.
  task automatic build(input logic [3:0] mask);
    expq.delete();
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        int  nrun;
        bit  tmo;
        push(4'b0, 4'(1 << i), 1'b0, 1'b1, 1'b0);
        m_cur = 2'(i);
        tmo  = (run_len[i] > MC - 1);
        nrun = tmo ? MC : run_len[i] + 1;
        for (int j = 0; j < nrun; j++) begin
          if (j > 0) begin
            m_x = px(i, j - 1); m_y = py(i, j - 1); m_col = pc(i, j - 1);
          end
          push(4'(1 << i), 4'b0, (j > 0), 1'b1, 1'b0);
        end
        if (tmo) m_err[i] = 1'b1;
        push(4'b0, 4'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    push(4'b0, 4'b0, 1'b0, 1'b1, 1'b1);
    push(4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.en = eng_enable; o.rs = eng_reset; o.we = fb_we; o.x = fb_x; o.y = fb_y;
    o.col = fb_color; o.busy = busy; o.done = done; o.cur = cur_eng; o.err = err;
    return o;
  endfunction

  // Launch a pass and compare every cycle; inj >= 0 injects a stray start and
  // a non-selected finished flag at that trace index.
  task automatic run_pass(input string name, input logic [3:0] mask, input int inj);
    build(mask);
    start = 1'b1;
    eng_mask = mask;
    @(posedge clk); #1;
    start = 1'b0;
    eng_mask = 4'($urandom);
    for (int k = 0; k < expq.size(); k++) begin
      obs_t a;
      a = sample();
      n_cmp++;
      if (a !== expq[k]) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got en=%b rs=%b we=%b x=%h y=%h c=%h busy=%b done=%b cur=%0d err=%b, want en=%b rs=%b we=%b x=%h y=%h c=%h busy=%b done=%b cur=%0d err=%b",
                 name, k, a.en, a.rs, a.we, a.x, a.y, a.col, a.busy, a.done, a.cur, a.err,
                 expq[k].en, expq[k].rs, expq[k].we, expq[k].x, expq[k].y, expq[k].col,
                 expq[k].busy, expq[k].done, expq[k].cur, expq[k].err);
      end
      if (k == inj) begin
        start = 1'b1;
        fin_force = 4'b0100;
      end else begin
        start = 1'b0;
        fin_force = '0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    fin_force = '0;
  endtask

  task automatic check_idle_zero(input string name);
    obs_t a;
    obs_t z;
    a = sample();
    z = '0;
    n_cmp++;
    if (a !== z) begin
      n_fail++;
      $display("FAIL %s: got en=%b rs=%b we=%b x=%h y=%h c=%h busy=%b done=%b cur=%0d err=%b, want all zero",
               name, a.en, a.rs, a.we, a.x, a.y, a.col, a.busy, a.done, a.cur, a.err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; eng_mask = '0; fin_force = '0;
    for (int i = 0; i < N; i++) begin
      run_len[i] = 3;
      cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_state");
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_idle_zero("idle_after_reset");
  endtask

  task automatic test_single();
    run_len[0] = 5;
    run_pass("single_eng0", 4'b0001, -1);
  endtask

  task automatic test_order();
    for (int i = 0; i < N; i++) run_len[i] = int'($urandom_range(0, 6));
    run_pass("order_1010", 4'b1010, -1);
  endtask

  task automatic test_empty();
    run_pass("empty_mask", 4'b0000, -1);
  endtask

  task automatic test_ignore();
    run_len[0] = 4;
    run_len[2] = 9;
    run_pass("ignore_start_fin", 4'b0001, 3);
  endtask

  task automatic test_midreset();
    run_len[1] = 6;
    start = 1'b1;
    eng_mask = 4'b0010;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_idle_zero("midrun_reset");
    @(posedge clk); #1;
    run_pass("restart_eng1", 4'b0010, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++) run_len[i] = int'($urandom_range(0, 7));
      run_pass("random_pass", 4'($urandom), -1);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end
  endtask

`ifdef VGA_SCHED_WDOG_EN
  task automatic test_wdog();
    run_len[2] = 1000;
    run_len[3] = 3;
    run_pass("wdog_eng2", 4'b1100, -1);
    run_len[0] = 2;
    run_pass("wdog_sticky", 4'b0001, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_order();
    test_empty();
    test_ignore();
    test_midreset();
    test_random();
`ifdef VGA_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
